// File: rtl/key_pkg.sv
// Shared constants for the pushbutton filter: board defaults, simulation-scale
// overrides and counter-width helpers.
package key_pkg;

    localparam int unsigned KEY_NUM_DEF    = 4;
    localparam int unsigned CNT_MAX_DEF    = 999_999;     // 20 ms at 50 MHz
    localparam int unsigned LONG_CNT_DEF   = 49_999_999;  // 1 s hold before repeat
    localparam int unsigned REPEAT_CNT_DEF = 9_999_999;   // 200 ms repeat period

    localparam int unsigned CNT_MAX_SIM    = 9;
    localparam int unsigned LONG_CNT_SIM   = 49;
    localparam int unsigned REPEAT_CNT_SIM = 19;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int unsigned CNT_W_DEF  = $clog2(CNT_MAX_DEF + 1);
    localparam int unsigned HOLD_W_DEF = $clog2(LONG_CNT_DEF + REPEAT_CNT_DEF + 1);

endpackage

// File: rtl/key_debounce_ch.sv
// Single-key synchroniser, debounce counter and press/release pulse generator.
// Auto-repeat on long hold is built only when KEY_REPEAT_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX    = CNT_MAX_DEF
`ifdef KEY_REPEAT_EN
  , parameter int unsigned LONG_CNT   = LONG_CNT_DEF
  , parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEF
`endif
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_state,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned CNT_W = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_state;
    logic             r_press;
    logic             r_release;
    logic [CNT_W-1:0] r_cnt;

    logic w_diff;
    logic w_accept;
    logic w_repeat;

    assign w_diff   = r_sync2 ^ r_state;
    assign w_accept = w_diff && (r_cnt == CNT_LAST);

`ifdef KEY_REPEAT_EN
    localparam int unsigned HOLD_W = cnt_width(LONG_CNT + REPEAT_CNT);
    localparam logic [HOLD_W-1:0] HOLD_FIRST  = HOLD_W'(LONG_CNT);
    localparam logic [HOLD_W-1:0] HOLD_TOP    = HOLD_W'(LONG_CNT + REPEAT_CNT);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(LONG_CNT + 1);

    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_next;

    // Hold count runs 1..HOLD_TOP then reloads just past LONG_CNT, so every
    // later pass through HOLD_TOP is one repeat period apart and it never wraps.
    always_comb begin
        w_hold_next = '0;
        w_repeat    = 1'b0;
        if (r_state && !w_accept) begin
            w_hold_next = (r_hold == HOLD_TOP) ? HOLD_RELOAD : r_hold + 1'b1;
            w_repeat    = (w_hold_next == HOLD_FIRST) || (w_hold_next == HOLD_TOP);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_hold_next;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= ~i_key_n;
            r_sync2   <= r_sync1;
            r_press   <= w_repeat;
            r_release <= 1'b0;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_state   <= r_sync2;
                r_cnt     <= '0;
                r_press   <= r_sync2;
                r_release <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_state   = r_state;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/key_filter.sv
// Debounces KEY_NUM active-low pushbuttons into levels and one-cycle pulses.
// Define KEY_REPEAT_EN to add auto-repeat press pulses on long holds.
module key_filter
    import key_pkg::*;
#(
    parameter int unsigned KEY_NUM    = KEY_NUM_DEF,
    parameter int unsigned CNT_MAX    = CNT_MAX_DEF
`ifdef KEY_REPEAT_EN
  , parameter int unsigned LONG_CNT   = LONG_CNT_DEF
  , parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEF
`endif
) (
    input  logic               clk_50M,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release
);

    for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_ch
        key_debounce_ch #(
            .CNT_MAX   (CNT_MAX)
`ifdef KEY_REPEAT_EN
          , .LONG_CNT  (LONG_CNT)
          , .REPEAT_CNT(REPEAT_CNT)
`endif
        ) u_ch (
            .i_clk    (clk_50M),
            .i_rst    (rst),
            .i_key_n  (key_in[gi]),
            .o_state  (key_state[gi]),
            .o_press  (key_press[gi]),
            .o_release(key_release[gi])
        );
    end

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter at simulation scale (CNT_MAX=9, LONG_CNT=49, REPEAT_CNT=19).
module tb_key_filter;
    import key_pkg::*;

    logic       clk_50M;
    logic       rst;
    logic [3:0] key_in;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;

    int total = 0;
    int bad   = 0;

    key_filter #(
        .KEY_NUM   (4),
        .CNT_MAX   (CNT_MAX_SIM)
`ifdef KEY_REPEAT_EN
      , .LONG_CNT  (LONG_CNT_SIM)
      , .REPEAT_CNT(REPEAT_CNT_SIM)
`endif
    ) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .key_in     (key_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release)
    );

    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    // Advance one edge; sample and drive 1 ns after it.
    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        key_in = 4'b1111;
        repeat (3) tick();
        total++; if (key_state !== 4'b0000) begin bad++; $display("FAIL reset_state: got %b want 0000", key_state); end
        total++; if (key_press !== 4'b0000) begin bad++; $display("FAIL reset_press: got %b want 0000", key_press); end
        total++; if (key_release !== 4'b0000) begin bad++; $display("FAIL reset_release: got %b want 0000", key_release); end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            total++;
            if ({key_state, key_press, key_release} !== 12'h000) begin
                bad++;
                $display("FAIL idle cycle %0d: state=%b press=%b release=%b want all 0", i, key_state, key_press, key_release);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] exp_p, exp_s;
        key_in[0] = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_p = (e == 12) ? 4'b0001 : 4'b0000;
            exp_s = (e >= 12) ? 4'b0001 : 4'b0000;
            total++; if (key_press !== exp_p) begin bad++; $display("FAIL clean_press edge %0d: press=%b want %b", e, key_press, exp_p); end
            total++; if (key_state !== exp_s) begin bad++; $display("FAIL clean_state edge %0d: state=%b want %b", e, key_state, exp_s); end
            total++; if (key_release !== 4'b0000) begin bad++; $display("FAIL clean_release edge %0d: release=%b want 0000", e, key_release); end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_p, exp_s;
        key_in[1] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 5) key_in[1] = 1'b1;
            total++; if (key_press !== 4'b0000) begin bad++; $display("FAIL bounce_early edge %0d: press=%b want 0000", e, key_press); end
        end
        key_in[1] = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_p = (e == 12) ? 4'b0010 : 4'b0000;
            exp_s = (e >= 12) ? 4'b0011 : 4'b0001;
            total++; if (key_press !== exp_p) begin bad++; $display("FAIL bounce_press edge %0d: press=%b want %b", e, key_press, exp_p); end
            total++; if (key_state !== exp_s) begin bad++; $display("FAIL bounce_state edge %0d: state=%b want %b", e, key_state, exp_s); end
        end
    endtask

    task automatic test_release();
        logic [3:0] exp_r, exp_s;
        key_in[0] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_r = (e == 12) ? 4'b0001 : 4'b0000;
            exp_s = (e >= 12) ? 4'b0010 : 4'b0011;
            total++; if (key_release !== exp_r) begin bad++; $display("FAIL release0 edge %0d: release=%b want %b", e, key_release, exp_r); end
            total++; if (key_state !== exp_s) begin bad++; $display("FAIL release0_state edge %0d: state=%b want %b", e, key_state, exp_s); end
            total++; if (key_press !== 4'b0000) begin bad++; $display("FAIL release0_press edge %0d: press=%b want 0000", e, key_press); end
        end
        key_in[1] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_r = (e == 12) ? 4'b0010 : 4'b0000;
            total++; if (key_release !== exp_r) begin bad++; $display("FAIL release1 edge %0d: release=%b want %b", e, key_release, exp_r); end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_p, exp_r;
        key_in[3:2] = 2'b00;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_p = (e == 12) ? 4'b1100 : 4'b0000;
            total++; if (key_press !== exp_p) begin bad++; $display("FAIL simul_press edge %0d: press=%b want %b", e, key_press, exp_p); end
        end
        key_in[3:2] = 2'b11;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_r = (e == 12) ? 4'b1100 : 4'b0000;
            total++; if (key_release !== exp_r) begin bad++; $display("FAIL simul_release edge %0d: release=%b want %b", e, key_release, exp_r); end
            total++; if (key_press !== 4'b0000) begin bad++; $display("FAIL simul_no_press edge %0d: press=%b want 0000", e, key_press); end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_p, exp_s;
        key_in[0] = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        total++; if ({key_state, key_press, key_release} !== 12'h000) begin
            bad++; $display("FAIL mid_reset_outputs: state=%b press=%b release=%b want all 0", key_state, key_press, key_release);
        end
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp_p = (e == 10) ? 4'b0001 : 4'b0000;
            exp_s = (e >= 10) ? 4'b0001 : 4'b0000;
            total++; if (key_press !== exp_p) begin bad++; $display("FAIL post_reset_press edge %0d: press=%b want %b", e, key_press, exp_p); end
            total++; if (key_state !== exp_s) begin bad++; $display("FAIL post_reset_state edge %0d: state=%b want %b", e, key_state, exp_s); end
        end
        key_in[0] = 1'b1;
        repeat (14) tick();
        total++; if (key_state !== 4'b0000) begin bad++; $display("FAIL post_reset_idle: state=%b want 0000", key_state); end
    endtask

    // Key 0 held 120 edges past acceptance, then released; release is accepted
    // 12 edges later, at hold count 132.
    task automatic test_hold();
        logic       exp_bit;
        logic [3:0] exp_r;
        key_in[0] = 1'b0;
        repeat (12) tick();
        total++; if (key_press !== 4'b0001) begin bad++; $display("FAIL hold_accept: press=%b want 0001", key_press); end
        for (int k = 1; k <= 134; k++) begin
            tick();
            exp_bit = 1'b0;
`ifdef KEY_REPEAT_EN
            if (k < 132 && k >= 49 && ((k - 49) % 19) == 0) exp_bit = 1'b1;
`endif
            exp_r = (k == 132) ? 4'b0001 : 4'b0000;
            total++; if (key_press !== {3'b000, exp_bit}) begin bad++; $display("FAIL hold_press k=%0d: press=%b want %b", k, key_press, {3'b000, exp_bit}); end
            total++; if (key_release !== exp_r) begin bad++; $display("FAIL hold_release k=%0d: release=%b want %b", k, key_release, exp_r); end
            if (k == 120) key_in[0] = 1'b1;
        end
    endtask

    initial begin
        rst    = 1'b1;
        key_in = 4'b1111;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid();
        test_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
